vgm_player: RTL and testbench

- Upstream command stage for the YM2149 PSG core.
- Consumes a VGM command byte stream over a valid/ready handshake. The header is already stripped; the first byte is the first command.
- Decodes AY-8910 register writes and wait commands, and paces them against a 44.1 kHz sample tick.
- Drives the PSG register-write port (reg/val/wr). The PSG latches on the rising edge of wr, so this block generates a clean high-then-low wr pulse per write.

---
 rtl/vgm_pkg.sv | 25 ++
 rtl/vgm_player_if.sv | 24 ++
 rtl/vgm_sample_tick.sv | 23 ++
 rtl/vgm_player.sv | 165 ++++++++++++++++
 tb/tb_vgm_player.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vgm_pkg.sv
// VGM command stream constants and FSM state encoding.
// Shared by the player and any future chip-specific players.
package vgm_pkg;

  localparam logic [7:0] OP_AY_WRITE   = 8'hA0;
  localparam logic [7:0] OP_WAIT_N     = 8'h61;
  localparam logic [7:0] OP_WAIT_735   = 8'h62;
  localparam logic [7:0] OP_WAIT_882   = 8'h63;
  localparam logic [3:0] OP_WAIT_SHORT = 4'h7;
  localparam logic [7:0] OP_END        = 8'h66;

  localparam logic [15:0] WAIT_NTSC = 16'd735;
  localparam logic [15:0] WAIT_PAL  = 16'd882;

  typedef enum logic [2:0] {
    S_CMD,
    S_ARG1,
    S_ARG2,
    S_WR_HI,
    S_WR_LO,
    S_WAIT,
    S_DONE
  } state_e;

endpackage

// File: rtl/vgm_player_if.sv
// Byte stream in, PSG register-write port and status flags out.
// The player is the slave; the stream source / PSG side is the master.
interface vgm_player_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       out_ready;
  logic [3:0] out_reg;
  logic [7:0] out_val;
  logic       out_wr;
  logic       out_done;
  logic       out_err;

  modport master (
    output in_byte, in_valid,
    input  out_ready, out_reg, out_val,
    input  out_wr, out_done, out_err
  );

  modport slave (
    input  in_byte, in_valid,
    output out_ready, out_reg, out_val,
    output out_wr, out_done, out_err
  );
endinterface

// File: rtl/vgm_sample_tick.sv
// Free-running sample-rate divider: one-cycle tick every SAMPLE_DIV clocks.
// Reusable by any VGM chip player.
module vgm_sample_tick #(
  parameter int unsigned SAMPLE_DIV = 567
) (
  input  logic in_clk,
  input  logic in_rst,
  output logic out_tick
);

  localparam logic [15:0] LAST = 16'(SAMPLE_DIV - 1);

  logic [15:0] cnt_q;

  assign out_tick = (cnt_q == LAST);

  always_ff @(posedge in_clk) begin
    if (in_rst)        cnt_q <= '0;
    else if (out_tick) cnt_q <= '0;
    else               cnt_q <= cnt_q + 16'd1;
  end

endmodule

// File: rtl/vgm_player.sv
// VGM command decoder driving the YM2149 register-write port.
// Paces wait commands against the 44.1 kHz sample tick.
module vgm_player
  import vgm_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 567,
  parameter int unsigned WR_HOLD    = 2
) (
  input logic        in_clk,
  input logic        in_rst,
  vgm_player_if.slave bus
);

  localparam logic [3:0] HOLD_LAST = 4'(WR_HOLD - 1);

  logic tick;

  vgm_sample_tick #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .out_tick (tick)
  );

  state_e      state_q, state_d;
  logic        op_wr_q, op_wr_d;
  logic [7:0]  arg_q, arg_d;
  logic [15:0] wait_q, wait_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  reg_q, reg_d;
  logic [7:0]  val_q, val_d;
  logic        wr_q, wr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        accept;
  logic [7:0]  b;

  assign b = bus.in_byte;
  assign bus.out_ready = (state_q == S_CMD) |
                         (state_q == S_ARG1) |
                         (state_q == S_ARG2);
  assign accept = bus.in_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    arg_d   = arg_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    reg_d   = reg_q;
    val_d   = val_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      S_CMD: if (accept) begin
        unique case (1'b1)
          b == OP_AY_WRITE: begin
            op_wr_d = 1'b1;
            state_d = S_ARG1;
          end
          b == OP_WAIT_N: begin
            op_wr_d = 1'b0;
            state_d = S_ARG1;
          end
          b == OP_WAIT_735: begin
            wait_d  = WAIT_NTSC;
            state_d = S_WAIT;
          end
          b == OP_WAIT_882: begin
            wait_d  = WAIT_PAL;
            state_d = S_WAIT;
          end
          b[7:4] == OP_WAIT_SHORT: begin
            wait_d  = 16'(b[3:0]) + 16'd1;
            state_d = S_WAIT;
          end
          b == OP_END: begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
          default: err_d = 1'b1;
        endcase
      end
      S_ARG1: if (accept) begin
        arg_d   = b;
        state_d = S_ARG2;
      end
      S_ARG2: if (accept) begin
        if (op_wr_q) begin
          // Bit 7 addresses a second chip we do not drive.
          if (arg_q[7]) begin
            state_d = S_CMD;
          end else begin
            reg_d   = arg_q[3:0];
            val_d   = b;
            hold_d  = '0;
            state_d = S_WR_HI;
          end
        end else begin
          wait_d  = {b, arg_q};
          state_d = ({b, arg_q} == 16'd0) ? S_CMD : S_WAIT;
        end
      end
      S_WR_HI: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = S_WR_LO;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_WR_LO: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = S_CMD;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      S_WAIT: if (tick) begin
        if (wait_q <= 16'd1) begin
          wait_d  = '0;
          state_d = S_CMD;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_CMD;
    endcase
    wr_d = (state_d == S_WR_HI);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= S_CMD;
      op_wr_q <= 1'b0;
      arg_q   <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      reg_q   <= '0;
      val_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      arg_q   <= arg_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_reg  = reg_q;
  assign bus.out_val  = val_q;
  assign bus.out_wr   = wr_q;
  assign bus.out_done = done_q;
  assign bus.out_err  = err_q;

endmodule

// File: tb/tb_vgm_player.sv
// Directed bench for vgm_player: scoreboard of PSG writes plus
// accept-timing and sample-tick accounting from a reference divider.
module tb_vgm_player;

  localparam int SDIV = 4;
  localparam int HOLD = 2;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;

  vgm_player_if bus ();

  vgm_player #(
    .SAMPLE_DIV (SDIV),
    .WR_HOLD    (HOLD)
  ) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edge bookkeeping: reference divider and accepted-byte log.
  int cyc = 0;
  int tk = 0;
  int div = 0;
  int last_tk_cyc = -1;
  bit t_now, acc_now;
  int a_cyc[$];
  int a_tka[$];
  int a_tick[$];
  int a_lt[$];

  // Scoreboard of expected {reg,val} writes.
  logic [11:0] exp_q[$];
  logic [11:0] cur = '0;
  logic        wr_prev = 1'b0;
  int          hi_len = 0;
  int          rise_cyc = -1;

  always @(posedge in_clk) begin
    cyc++;
    t_now   = !in_rst && (div == SDIV - 1);
    acc_now = !in_rst && bus.in_valid && bus.out_ready;
    if (in_rst || t_now) div = 0;
    else                 div++;
    if (acc_now) begin
      a_lt.push_back(last_tk_cyc);
      a_cyc.push_back(cyc);
      a_tka.push_back(tk + int'(t_now));
      a_tick.push_back(int'(t_now));
    end
    if (t_now) begin
      tk++;
      last_tk_cyc = cyc;
    end
    #1;
    if (in_rst) begin
      wr_prev = 1'b0;
      hi_len  = 0;
    end else begin
      if (bus.out_wr && !wr_prev) begin
        rise_cyc = cyc;
        hi_len   = 1;
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_wr: got reg %0h val %0h, none expected",
                   bus.out_reg, bus.out_val);
        end else begin
          cur = exp_q.pop_front();
          chk("wr_reg", 32'(bus.out_reg), 32'(cur[11:8]));
          chk("wr_val", 32'(bus.out_val), 32'(cur[7:0]));
        end
      end else if (bus.out_wr) begin
        hi_len++;
        chk("wr_stable", 32'({bus.out_reg, bus.out_val}), 32'(cur));
      end else if (wr_prev) begin
        chk("wr_hi_len", 32'(hi_len), 32'(HOLD));
      end
      wr_prev = bus.out_wr;
    end
  end

  // Caller sits at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [7:0] b, input int budget = 20);
    int n0;
    int k;
    n0 = a_cyc.size();
    k  = 0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
    @(negedge in_clk);
    while (a_cyc.size() == n0 && k < budget) begin
      @(negedge in_clk);
      k++;
    end
    if (a_cyc.size() == n0) begin
      n_assert++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0h not accepted in %0d cycles",
               b, budget);
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
  endtask

  function automatic int li();
    return a_cyc.size() - 1;
  endfunction

  function automatic int ticks_between(input int i0, input int i1);
    return (a_tka[i1] - a_tick[i1]) - a_tka[i0];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int i0;
    int n0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    in_rst = 1'b1;
    repeat (3) @(negedge in_clk);
    chk("rst_wr",    32'(bus.out_wr),    0);
    chk("rst_reg",   32'(bus.out_reg),   0);
    chk("rst_val",   32'(bus.out_val),   0);
    chk("rst_done",  32'(bus.out_done),  0);
    chk("rst_err",   32'(bus.out_err),   0);
    chk("rst_ready", 32'(bus.out_ready), 1);
    in_rst = 1'b0;

    // 1: plain register write, valid held high
    exp_q.push_back({4'h7, 8'h3E});
    push(8'hA0);
    push(8'h07);
    push(8'h3E);
    c = a_cyc[li()];
    push(8'hA0);
    chk("t1_ready_return", 32'(a_cyc[li()] - c), 5);
    chk("t1_rise_cyc", 32'(rise_cyc), 32'(c));

    // 2: second-chip write is dropped
    push(8'h88);
    push(8'h55);
    c = a_cyc[li()];
    push(8'h7F);
    chk("t2_next_accept", 32'(a_cyc[li()] - c), 1);
    chk("t2_reg_kept", 32'(bus.out_reg), 32'h7);
    chk("t2_val_kept", 32'(bus.out_val), 32'h3E);

    // 3: 0x7F waits 16 ticks
    i0 = li();
    exp_q.push_back({4'h0, 8'h01});
    push(8'hA0, 200);
    chk("t3_ticks", 32'(ticks_between(i0, li())), 16);
    chk("t3_last_tick", 32'(a_lt[li()]), 32'(a_cyc[li()] - 1));
    push(8'h00);
    push(8'h01);

    // 4: zero-length 0x61, then 3-tick 0x61
    exp_q.push_back({4'h1, 8'h02});
    push(8'h61);
    push(8'h00);
    push(8'h00);
    c = a_cyc[li()];
    push(8'hA0);
    chk("t4_zero_wait", 32'(a_cyc[li()] - c), 1);
    push(8'h01);
    push(8'h02);
    push(8'h61);
    push(8'h03);
    push(8'h00);
    i0 = li();
    push(8'h42, 200);
    chk("t4_ticks", 32'(ticks_between(i0, li())), 3);
    chk("t4_last_tick", 32'(a_lt[li()]), 32'(a_cyc[li()] - 1));

    // 5: unsupported opcode, end-of-data, then reset
    chk("t5_err_set", 32'(bus.out_err), 1);
    chk("t5_done_clr", 32'(bus.out_done), 0);
    push(8'h66);
    chk("t5_done_set", 32'(bus.out_done), 1);
    chk("t5_ready_low", 32'(bus.out_ready), 0);
    n0 = a_cyc.size();
    bus.in_byte  = 8'hA0;
    bus.in_valid = 1'b1;
    repeat (30) @(negedge in_clk);
    chk("t5_no_accept", 32'(a_cyc.size() - n0), 0);
    chk("t5_err_hold", 32'(bus.out_err), 1);
    idle();
    in_rst = 1'b1;
    @(negedge in_clk);
    in_rst = 1'b0;
    chk("t5_rst_done", 32'(bus.out_done), 0);
    chk("t5_rst_err", 32'(bus.out_err), 0);
    chk("t5_rst_ready", 32'(bus.out_ready), 1);

    // 6: reset during a long wait and during WR_HI
    push(8'h62);
    idle();
    repeat (20) @(negedge in_clk);
    chk("t6_in_wait", 32'(bus.out_ready), 0);
    in_rst = 1'b1;
    @(negedge in_clk);
    in_rst = 1'b0;
    chk("t6_wait_rst_wr", 32'(bus.out_wr), 0);
    chk("t6_wait_rst_ready", 32'(bus.out_ready), 1);
    exp_q.push_back({4'h3, 8'h11});
    push(8'hA0);
    push(8'h03);
    push(8'h11);
    idle();
    chk("t6_wr_hi", 32'(bus.out_wr), 1);
    in_rst = 1'b1;
    @(negedge in_clk);
    chk("t6_hi_rst_wr", 32'(bus.out_wr), 0);
    chk("t6_hi_rst_ready", 32'(bus.out_ready), 1);
    in_rst = 1'b0;
    exp_q.push_back({4'hF, 8'hFF});
    push(8'hA0);
    push(8'h0F);
    push(8'hFF);
    idle();
    repeat (10) @(negedge in_clk);
    chk("t6_reg", 32'(bus.out_reg), 32'hF);
    chk("t6_val", 32'(bus.out_val), 32'hFF);
    chk("t6_ready", 32'(bus.out_ready), 1);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
